// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if
//   Control, table-load and tone-generator-facing signals of note_sequencer.
//   master : controller side (drives start/stop/loop/tempo and the load bus,
//            observes div/gate/busy/step_idx/done)
//   slave  : note_sequencer side
//
//   start     1              single-cycle request to begin playback at step 0
//   stop      1              single-cycle request to abort playback
//   loop      1              1 = wrap after last step, 0 = finish
//   tempo     WIDTH_TEMPO    clock cycles per beat (0 treated as 1)
//   load_en   1              table write strobe
//   load_addr log2(NUM_STEPS) table write index
//   load_div  WIDTH_COUNTER  divider value to store (0 = rest)
//   load_len  2              note length minus one, in beats
//   div       WIDTH_COUNTER  divider value for the tone generator
//   gate      1              1 = note sounding
//   busy      1              1 = sequencer not idle
//   step_idx  log2(NUM_STEPS) index of the current step
//   done      1              one-cycle pulse when one-shot playback completes
// ---------------------------------------------------------------------------
interface note_sequencer_if #(
    parameter int WIDTH_COUNTER = 10,
    parameter int WIDTH_TEMPO   = 16,
    parameter int NUM_STEPS     = 8
);
    localparam int AW = $clog2(NUM_STEPS);

    logic                     start;
    logic                     stop;
    logic                     loop;
    logic [WIDTH_TEMPO-1:0]   tempo;
    logic                     load_en;
    logic [AW-1:0]            load_addr;
    logic [WIDTH_COUNTER-1:0] load_div;
    logic [1:0]               load_len;
    logic [WIDTH_COUNTER-1:0] div;
    logic                     gate;
    logic                     busy;
    logic [AW-1:0]            step_idx;
    logic                     done;

    modport master (
        output start, stop, loop, tempo, load_en, load_addr, load_div, load_len,
        input  div, gate, busy, step_idx, done
    );

    modport slave (
        input  start, stop, loop, tempo, load_en, load_addr, load_div, load_len,
        output div, gate, busy, step_idx, done
    );
endinterface

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Plays a programmable table of notes (divider + length in beats) at a
//   programmable tempo, feeding the square-wave tone generator's divider and
//   gate. One-shot or looped playback, live table loading, abort.
//
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    note_sequencer_if.slave: start/stop/loop/tempo control, table load
//          bus, and registered outputs div/gate/busy/step_idx/done
// ---------------------------------------------------------------------------
module note_sequencer #(
    parameter int WIDTH_COUNTER = 10,
    parameter int WIDTH_TEMPO   = 16,
    parameter int NUM_STEPS     = 8,
    parameter int GAP_CYCLES    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    note_sequencer_if.slave bus
);
    localparam int AW = $clog2(NUM_STEPS);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW-1:0] LAST_STEP = AW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            step_q, step_d;
    logic [WIDTH_COUNTER-1:0] div_q, div_d;
    logic                     gate_q, gate_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [1:0]               len_q, len_d;
    logic [1:0]               beat_q, beat_d;
    logic [WIDTH_TEMPO-1:0]   cyc_q, cyc_d;
    logic [GW-1:0]            gap_q, gap_d;

    logic [WIDTH_COUNTER-1:0] tbl_div [NUM_STEPS];
    logic [1:0]               tbl_len [NUM_STEPS];

    logic [WIDTH_TEMPO-1:0]   t_last;
    logic                     beat_end;
    logic                     do_enter;
    logic                     do_idle;
    logic                     do_done;
    logic                     do_advance;
    logic [AW-1:0]            enter_idx;

    // Table: writes land at the clock edge, so a step entered in the same
    // cycle as a write to its own entry still reads the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                tbl_div[i] <= '0;
                tbl_len[i] <= '0;
            end
        end else if (bus.load_en) begin
            tbl_div[bus.load_addr] <= bus.load_div;
            tbl_len[bus.load_addr] <= bus.load_len;
        end
    end

    // ">=" rather than "==" so a tempo lowered mid-beat ends the beat at once
    assign t_last   = (bus.tempo == '0) ? '0 : bus.tempo - 1'b1;
    assign beat_end = (cyc_q >= t_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            div_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            div_q   <= div_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        div_d      = div_q;
        gate_d     = gate_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_d      = len_q;
        beat_d     = beat_q;
        cyc_d      = cyc_q;
        gap_d      = gap_q;
        do_enter   = 1'b0;
        do_idle    = 1'b0;
        do_done    = 1'b0;
        do_advance = 1'b0;
        enter_idx  = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    do_enter  = 1'b1;
                    enter_idx = '0;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    do_idle = 1'b1;
                end else if (beat_end) begin
                    if (beat_q == len_q) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            gate_d  = 1'b0;
                            gap_d   = '0;
                        end else begin
                            do_advance = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        cyc_d  = '0;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            GAP: begin
                if (bus.stop) begin
                    do_idle = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    do_advance = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: do_idle = 1'b1;
        endcase

        // NUM_STEPS is a power of two, so step_q + 1 wraps to 0 after the last step
        if (do_advance) begin
            if (step_q == LAST_STEP && !bus.loop) begin
                do_idle = 1'b1;
                do_done = 1'b1;
            end else begin
                do_enter  = 1'b1;
                enter_idx = step_q + 1'b1;
            end
        end

        if (do_enter) begin
            state_d = PLAY;
            step_d  = enter_idx;
            div_d   = tbl_div[enter_idx];
            gate_d  = (tbl_div[enter_idx] != '0);
            len_d   = tbl_len[enter_idx];
            beat_d  = '0;
            cyc_d   = '0;
            gap_d   = '0;
            busy_d  = 1'b1;
        end

        if (do_idle) begin
            state_d = IDLE;
            step_d  = '0;
            div_d   = '0;
            gate_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = do_done;
            beat_d  = '0;
            cyc_d   = '0;
            gap_d   = '0;
        end
    end

    assign bus.div      = div_q;
    assign bus.gate     = gate_q;
    assign bus.busy     = busy_q;
    assign bus.step_idx = step_q;
    assign bus.done     = done_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream control stage for the square-wave tone generator.
- Holds a small programmable table of notes, each a divider value plus a duration in beats, and plays them in order at a programmable tempo.
- Drives the generator's divider input and a gate; the gate mutes the generator or holds it in reset between notes.
- Supports one-shot and looped playback, live table loading and abort.

Parameters:
WIDTH_COUNTER, 10, width of divider values stored and output (matches the tone generator's divider width)
WIDTH_TEMPO, 16, width of the tempo input (clock cycles per beat)
NUM_STEPS, 8, number of table entries; power of two, minimum 2
GAP_CYCLES, 2, silent cycles inserted after every note; 0 means no gap

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin playback from step 0
stop  input  1  single-cycle request to abort playback
loop  input  1  1 = wrap to step 0 after the last step; 0 = finish after the last step
tempo  input  WIDTH_TEMPO  clock cycles per beat; 0 is treated as 1
load_en  input  1  table write strobe
load_addr  input  log2(NUM_STEPS)  table write index
load_div  input  WIDTH_COUNTER  divider value to store; 0 = rest
load_len  input  2  note length minus one, in beats (1 to 4 beats)
div  output  WIDTH_COUNTER  divider value for the tone generator
gate  output  1  1 = note sounding
busy  output  1  1 = state is not IDLE
step_idx  output  log2(NUM_STEPS)  index of the current step
done  output  1  one-cycle pulse when one-shot playback completes

Behaviour:
- Reset (rst_n low, async):
  - Outputs: div=0, gate=0, busy=0, done=0, step_idx=0.
  - Internal: state=IDLE, all counters 0, every table entry cleared to div=0, len=0.
- States: IDLE, PLAY, GAP. All outputs are registered.
- Table writes:
  - On any cycle with load_en=1, table[load_addr] <= {load_div, load_len}. Writes are accepted in every state.
  - A step's entry is latched into div/gate only when that step is entered.
  - A write to the entry being entered in the same cycle is not seen: the old value is used.
- IDLE:
  - start=1 and stop=0 -> PLAY next cycle.
  - On that transition: step_idx=0, div=table[0].div, gate=(table[0].div!=0), beat and cycle counters cleared, busy=1.
  - Latency from the start edge to gate/div valid is one cycle.
- PLAY:
  - Cycle counter counts 0 to T-1, where T=max(tempo,1); at T-1 it wraps and the beat counter increments.
  - The compare is cyc_cnt >= T-1, so lowering tempo mid-beat ends the beat on the next cycle rather than waiting for a wrap.
  - Note end is the cycle with beat_cnt==len and cyc_cnt>=T-1. The note is gate-high for exactly (len+1)*T cycles, or 0 cycles if div=0.
  - At note end with GAP_CYCLES>0 -> GAP: gate=0, div held.
  - At note end with GAP_CYCLES=0 -> advance directly.
- GAP: counts GAP_CYCLES cycles with gate=0, then advances.
- Advance:
  - step_idx < NUM_STEPS-1: step_idx+1, load that entry as on PLAY entry, state PLAY.
  - Last step with loop=1: wrap to step 0, state PLAY, no done pulse.
  - Last step with loop=0: state IDLE, div=0, gate=0, busy=0, done=1 for exactly one cycle, step_idx=0.
  - loop is sampled at the advance cycle only.
- stop:
  - In PLAY or GAP: state IDLE next cycle, gate=0, div=0, busy=0, step_idx=0, no done pulse.
  - In IDLE: no effect.
- Priority: rst_n > stop > start. start while busy is ignored. start and stop in the same IDLE cycle: stay IDLE.
- tempo, loop and table contents may change at any time without glitching gate. gate changes only at step entry, note end or stop.

Test Plan:
- Reset mid-PLAY -> rst_n low: div, gate, busy, done and step_idx go to 0 asynchronously; a following start plays from step 0 using cleared entries (gate stays 0).
- Load step0={div=100,len=1}, step1={div=50,len=0}, remaining entries div=0, len=0; tempo=4, loop=0, GAP_CYCLES=2; pulse start ->
  - cycle+1: div=100, gate=1 for 8 cycles; then gate=0 for 2 cycles.
  - Then div=50, gate=1 for 4 cycles.
  - Steps 2-7 are rests of 4 gate-low cycles each, plus gaps.
  - done pulses once, busy falls in the same cycle.
- Same table with loop=1 -> after step 7's gap, step_idx=0, div=100, gate=1; no done pulse. Pulse stop mid-note -> next cycle gate=0, div=0, busy=0, done=0.
- tempo=0 with step0 len=0 -> step0 sounds for exactly 1 cycle. Separately, tempo changed 16->2 at cyc_cnt=5 -> that beat ends on the next cycle.
- Write load_addr=1 while step 0 plays -> new step 1 values appear on entry. Write load_addr=1 in the exact step 1 entry cycle -> old value output.
- start and stop asserted together in IDLE -> remains IDLE, busy=0. start pulsed during PLAY -> ignored, step sequence unchanged.
